// File: rtl/alu_cmd_engine.sv
// Packet-driven byte engine: echoes payloads or sums little-endian 32-bit words.
// Optional ADD opcode (0xAD) is compiled in only when ALU_ADD_EN is defined.
module alu_cmd_engine (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       busy_o,
   output logic       err_o
);

   typedef enum logic [2:0] {
      OPCODE, RSVD, LEN_LO, LEN_HI, ECHO, ADD, SEND_SUM, DROP
   } state_t;

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;

   state_t      state, state_nxt;
   logic        run;
   logic        err_nxt;
   logic [7:0]  opcode, len_lo;
   logic [15:0] len, remain;
   logic        out_free, s_fire, last_byte, load_echo, load_sum;
   logic [7:0]  sum_byte;
   logic [1:0]  byte_idx;

   assign len       = {s_axis_tdata, len_lo};
   assign out_free  = !m_axis_tvalid || m_axis_tready;
   assign s_fire    = s_axis_tvalid && s_axis_tready;
   assign last_byte = (remain == 16'd1);
   assign load_echo = s_fire && (state == ECHO);
   assign busy_o    = (state != OPCODE);

   // run holds tready low until the first edge after reset release
   always_comb begin
      s_axis_tready = 1'b0;
      case (state)
         ECHO:     s_axis_tready = run && out_free;
         SEND_SUM: s_axis_tready = 1'b0;
         default:  s_axis_tready = run;
      endcase
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      case (state)
         OPCODE: if (s_fire) state_nxt = RSVD;
         RSVD:   if (s_fire) state_nxt = LEN_LO;
         LEN_LO: if (s_fire) state_nxt = LEN_HI;
         LEN_HI: if (s_fire) begin
            if (len < 16'd4) begin
               state_nxt = OPCODE;
               err_nxt   = 1'b1;
            end else if (len == 16'd4) begin
               state_nxt = OPCODE;
            end else if (opcode == OP_ECHO) begin
               state_nxt = ECHO;
`ifdef ALU_ADD_EN
            end else if (opcode == OP_ADD) begin
               state_nxt = ADD;
`endif
            end else begin
               state_nxt = DROP;
               err_nxt   = 1'b1;
            end
         end
         ECHO: if (s_fire && last_byte) state_nxt = OPCODE;
`ifdef ALU_ADD_EN
         ADD: if (s_fire && last_byte) begin
            state_nxt = SEND_SUM;
            err_nxt   = (byte_idx != 2'd3);
         end
         SEND_SUM: if (out_free && byte_idx == 2'd3) state_nxt = OPCODE;
`endif
         DROP: if (s_fire && last_byte) state_nxt = OPCODE;
         default: state_nxt = OPCODE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= OPCODE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run           <= 1'b0;
         err_o         <= 1'b0;
         opcode        <= 8'h00;
         len_lo        <= 8'h00;
         remain        <= 16'h0000;
         m_axis_tdata  <= 8'h00;
         m_axis_tvalid <= 1'b0;
      end else begin
         run   <= 1'b1;
         err_o <= err_nxt;
         if (s_fire && state == OPCODE) opcode <= s_axis_tdata;
         if (s_fire && state == LEN_LO) len_lo <= s_axis_tdata;
         if (s_fire && state == LEN_HI)
            remain <= len - 16'd4;
         else if (s_fire && (state == ECHO || state == ADD || state == DROP))
            remain <= remain - 16'd1;
         // single-entry output register shared by echo and sum bytes
         if (load_echo) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
         end else if (load_sum) begin
            m_axis_tdata  <= sum_byte;
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

`ifdef ALU_ADD_EN
   logic [31:0] acc;
   logic [23:0] word;

   assign load_sum = (state == SEND_SUM) && out_free;
   assign sum_byte = acc[8*byte_idx +: 8];

   // byte_idx is the lane within the current word while adding, then the sum byte being sent
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc      <= 32'h0;
         word     <= 24'h0;
         byte_idx <= 2'd0;
      end else if (s_fire && state == LEN_HI) begin
         acc      <= 32'h0;
         byte_idx <= 2'd0;
      end else if (s_fire && state == ADD) begin
         case (byte_idx)
            2'd0:    word[7:0]   <= s_axis_tdata;
            2'd1:    word[15:8]  <= s_axis_tdata;
            2'd2:    word[23:16] <= s_axis_tdata;
            default: acc <= acc + {s_axis_tdata, word};
         endcase
         byte_idx <= last_byte ? 2'd0 : byte_idx + 2'd1;
      end else if (load_sum) begin
         byte_idx <= byte_idx + 2'd1;
      end
   end
`else
   assign load_sum = 1'b0;
   assign sum_byte = 8'h00;
   assign byte_idx = 2'd0;
`endif

endmodule

// File: doc/alu_cmd_engine.md
ALU_CMD_ENGINE -- requirements
Module: alu_cmd_engine

Interface
REQ-001 SHALL have no parameters; byte width 8, length field 16 bits, accumulator 32 bits.
REQ-002 SHALL have port clk_i, input, 1 bit: sole clock; all state on rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port s_axis_tdata, input, 8 bits: command byte from the UART receiver.
REQ-005 SHALL have port s_axis_tvalid, input, 1 bit: command byte valid.
REQ-006 SHALL have port s_axis_tready, output, 1 bit: engine accepts command byte.
REQ-007 SHALL have port m_axis_tdata, output, 8 bits: response byte to the UART transmitter.
REQ-008 SHALL have port m_axis_tvalid, output, 1 bit: response byte valid.
REQ-009 SHALL have port m_axis_tready, input, 1 bit: transmitter accepts response byte.
REQ-010 SHALL have port busy_o, output, 1 bit: high whenever state is not OPCODE.
REQ-011 SHALL have port err_o, output, 1 bit: one-cycle pulse on a malformed or unknown packet.

Function
REQ-012 SHALL parse packets as: opcode, reserved, LEN_LO, LEN_HI, then payload; LEN is total packet bytes including the 4-byte header.
REQ-013 SHALL use states OPCODE, RSVD, LEN_LO, LEN_HI, ECHO, ADD, SEND_SUM, DROP.
REQ-014 SHALL transfer a byte only on a cycle where valid and ready are both high; each header state advances on one transfer.
REQ-015 SHALL hold s_axis_tready high in OPCODE, RSVD, LEN_LO, LEN_HI, ADD and DROP.
REQ-016 SHALL, in LEN_HI, go to OPCODE with no response when LEN == 4, and go to OPCODE with an err_o pulse when LEN < 4.
REQ-017 SHALL, in LEN_HI with LEN > 4, go to ECHO for opcode 0xEC, ADD for opcode 0xAD, and DROP for any other opcode (err_o pulse at the LEN_HI transfer).
REQ-018 SHALL, in ECHO, forward each payload byte through a one-entry output register: 1-cycle latency, s_axis_tready = !m_axis_tvalid || m_axis_tready.
REQ-019 SHALL order ECHO output bytes exactly as received, with no loss or duplication under arbitrary m_axis_tready stalls.
REQ-020 SHALL leave ECHO after the last payload byte (LEN-4 bytes) is accepted; the final byte may still be draining in the output register.
REQ-021 SHALL, in ADD, assemble little-endian 32-bit words and add each complete word to the accumulator modulo 2^32, with the accumulator cleared at packet start.
REQ-022 SHALL, when the ADD payload length is not a multiple of 4, ignore the trailing partial word and pulse err_o on the last byte.
REQ-023 SHALL, after the last ADD byte, enter SEND_SUM and emit 4 bytes LSB first, with s_axis_tready low, advancing on each m_axis transfer.
REQ-024 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-025 SHALL, in DROP, consume and discard LEN-4 bytes with no response, then return to OPCODE.
REQ-026 SHALL accept the opcode of the next packet while the last echo byte is still draining, with no extra idle cycle required.

Reset
REQ-027 SHALL, while rst_ni is low, force: state OPCODE, s_axis_tready 0, m_axis_tvalid 0, m_axis_tdata 0x00, busy_o 0, err_o 0, accumulator 0, counters 0.
REQ-028 SHALL abandon any in-flight packet or pending response byte on reset assertion; the first byte after release is treated as an opcode.
REQ-029 SHALL raise s_axis_tready on the first clock edge after rst_ni deasserts.

Configuration
REQ-030 SHALL, with ALU_ADD_EN defined, implement opcode 0xAD per REQ-021 to REQ-023.
REQ-031 SHALL, with ALU_ADD_EN undefined, treat 0xAD as unknown (DROP plus err_o), omitting the accumulator, ADD and SEND_SUM logic.

Verification
REQ-032 SHALL verify echo: EC 00 07 00 41 42 43 -> 41 42 43, busy_o back to 0, err_o never high.
REQ-033 SHALL verify add: AD 00 0C 00 01 00 00 00 FF FF FF FF -> 00 00 00 00 (wrap).
REQ-034 SHALL verify backpressure: echo of 16 bytes with m_axis_tready toggling randomly -> identical 16 bytes out, in order.
REQ-035 SHALL verify unknown opcode: 5A 00 06 00 11 22 then EC 00 05 00 99 -> err_o pulses once, output is only 99.
REQ-036 SHALL verify bad length and ADD remainder: EC 00 02 00 -> err_o pulse; AD 00 06 00 01 02 -> err_o pulse, response 00 00 00 00.
REQ-037 SHALL verify reset mid-packet: rst_ni low after EC 00 08 00 01 -> no output; then EC 00 05 00 7E -> 7E.
